spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sync.sv | 20 ++
 rtl/spi_slave.sv | 169 ++++++++++++++++
 tb/tb_spi_slave.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: FSM encoding and mode decode helpers.
package spi_pkg;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   function automatic logic cpol(input logic [1:0] mode);
      return mode[1];
   endfunction

   function automatic logic cpha(input logic [1:0] mode);
      return mode[0];
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with a configurable reset value.
module spi_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) sync_q <= {2{RST_VAL}};
      else         sync_q <= {sync_q[0], d_i};
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave: oversampled sclk/ss/mosi, all four modes, TX shadow register.
module spi_slave
   import spi_pkg::*;
#(
   parameter logic [1:0] MODE     = 2'b00,
   parameter int         BITS_NUM = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sclk,
   input  logic                ss,
   input  logic                mosi,
   output logic                miso,
   input  logic [BITS_NUM-1:0] tx_data,
   input  logic                tx_load,
   output logic                tx_ready,
   output logic [BITS_NUM-1:0] rx_data,
   output logic                rx_valid,
   output logic                busy,
   output logic                tx_underrun
);

   localparam int            CW   = (BITS_NUM > 1) ? $clog2(BITS_NUM) : 1;
   localparam logic [CW-1:0] LAST = CW'(BITS_NUM - 1);
   localparam logic          POL  = cpol(MODE);
   localparam logic          PHA  = cpha(MODE);

   logic sclk_s, ss_s, mosi_s;
   logic sclk_h_q, ss_h_q;
   logic [1:0] settle_q;
   logic armed_q;

   logic [0:0]          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [BITS_NUM-1:0] shift_q, shift_d;
   logic [BITS_NUM-1:0] rx_sh_q, rx_sh_d;
   logic [BITS_NUM-1:0] shadow_q, shadow_d;
   logic [BITS_NUM-1:0] rx_data_q, rx_data_d;
   logic tx_ready_q, tx_ready_d;
   logic rx_valid_q, rx_valid_d;
   logic unrun_q, unrun_d;
   logic pend_q, pend_d;
   logic start;

   spi_sync #(.RST_VAL(POL)) u_sync_sclk (
      .clk_i(clk), .rst_ni(reset), .d_i(sclk), .q_o(sclk_s)
   );
   spi_sync #(.RST_VAL(1'b1)) u_sync_ss (
      .clk_i(clk), .rst_ni(reset), .d_i(ss), .q_o(ss_s)
   );
   spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
      .clk_i(clk), .rst_ni(reset), .d_i(mosi), .q_o(mosi_s)
   );

   logic active, rise, fall, lead, trail, samp, shft;
   logic ss_fall, ss_rise;

   assign active  = (state_q == ST_ACTIVE);
   assign rise    = sclk_s & ~sclk_h_q;
   assign fall    = ~sclk_s & sclk_h_q;
   assign lead    = POL ? fall : rise;
   assign trail   = POL ? rise : fall;
   assign samp    = PHA ? trail : lead;
   assign shft    = PHA ? lead : trail;
   // A fall is only trusted once ss has been seen high after reset.
   assign ss_fall = armed_q & ss_h_q & ~ss_s;
   assign ss_rise = ~ss_h_q & ss_s;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      rx_sh_d    = rx_sh_q;
      shadow_d   = shadow_q;
      rx_data_d  = rx_data_q;
      tx_ready_d = tx_ready_q;
      rx_valid_d = 1'b0;
      unrun_d    = 1'b0;
      pend_d     = pend_q;
      start      = 1'b0;
      if (!active) begin
         if (ss_fall) begin
            state_d = ST_ACTIVE;
            start   = !PHA;
         end
      end else if (ss_rise) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         pend_d  = 1'b0;
      end else begin
         start = PHA ? (shft && cnt_q == '0) : (samp && pend_q);
         if (samp) begin
            rx_sh_d = {rx_sh_q[BITS_NUM-2:0], mosi_s};
            if (cnt_q == LAST) begin
               cnt_d      = '0;
               rx_data_d  = rx_sh_d;
               rx_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         if (shft) begin
            shift_d = {shift_q[BITS_NUM-2:0], 1'b0};
            // CPHA=0: next word is committed on its first sample edge.
            if (!PHA && cnt_q == '0) pend_d = 1'b1;
         end
      end
      if (start) begin
         pend_d = 1'b0;
         if (!tx_ready_q) begin
            shift_d    = shadow_q;
            tx_ready_d = !tx_load;
            if (tx_load) shadow_d = tx_data;
         end else if (tx_load) begin
            shift_d = tx_data;
         end else begin
            shift_d = '0;
            unrun_d = 1'b1;
         end
      end else if (tx_load && tx_ready_q) begin
         shadow_d   = tx_data;
         tx_ready_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sclk_h_q   <= POL;
         ss_h_q     <= 1'b1;
         settle_q   <= 2'd0;
         armed_q    <= 1'b0;
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         rx_sh_q    <= '0;
         shadow_q   <= '0;
         rx_data_q  <= '0;
         tx_ready_q <= 1'b1;
         rx_valid_q <= 1'b0;
         unrun_q    <= 1'b0;
         pend_q     <= 1'b0;
      end else begin
         sclk_h_q   <= sclk_s;
         ss_h_q     <= ss_s;
         if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
         if (settle_q == 2'd3 && ss_s) armed_q <= 1'b1;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         rx_sh_q    <= rx_sh_d;
         shadow_q   <= shadow_d;
         rx_data_q  <= rx_data_d;
         tx_ready_q <= tx_ready_d;
         rx_valid_q <= rx_valid_d;
         unrun_q    <= unrun_d;
         pend_q     <= pend_d;
      end
   end

   assign miso = !active ? 1'b0
               : (!PHA && pend_q) ? (!tx_ready_q && shadow_q[BITS_NUM-1])
               : shift_q[BITS_NUM-1];
   assign tx_ready    = tx_ready_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign busy        = active;
   assign tx_underrun = unrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench: one spi_slave per SPI mode, driven by a bit-banged master.
module tb_spi_slave;

   localparam int H = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] sclk = 4'b1100;
   logic [3:0] ss = 4'hF;
   logic [3:0] mosi = 4'h0;
   logic [3:0] miso;
   logic [3:0] tx_load = 4'h0;
   logic [3:0] tx_ready, rx_valid, busy, tx_underrun;
   logic [7:0] tx_data [4];
   logic [7:0] rx_data [4];

   int checks = 0;
   int failures = 0;
   int rxc [4];
   int unc [4];
   logic [7:0] rxh [4][64];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_slave #(.MODE(2'(g)), .BITS_NUM(8)) u_dut (
         .clk(clk), .reset(reset),
         .sclk(sclk[g]), .ss(ss[g]), .mosi(mosi[g]),
         .miso(miso[g]),
         .tx_data(tx_data[g]), .tx_load(tx_load[g]),
         .tx_ready(tx_ready[g]),
         .rx_data(rx_data[g]), .rx_valid(rx_valid[g]),
         .busy(busy[g]), .tx_underrun(tx_underrun[g])
      );
   end

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (rx_valid[i] === 1'b1) begin
            rxh[i][rxc[i] % 64] <= rx_data[i];
            rxc[i] <= rxc[i] + 1;
         end
         if (tx_underrun[i] === 1'b1) unc[i] <= unc[i] + 1;
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input int g, input logic [7:0] v);
      @(negedge clk);
      tx_data[g] = v;
      tx_load[g] = 1'b1;
      @(negedge clk);
      tx_load[g] = 1'b0;
   endtask

   task automatic ss_low(input int g);
      ss[g] = 1'b0;
      wait_clk(H);
   endtask

   task automatic ss_high(input int g);
      ss[g] = 1'b1;
      wait_clk(H);
   endtask

   task automatic wait_ready(input int g);
      int n = 0;
      while (tx_ready[g] !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (tx_ready[g] !== 1'b1) begin
         failures++;
         $display("FAIL wait_ready dut%0d: tx_ready=%b required 1", g, tx_ready[g]);
      end
   endtask

   task automatic xfer(input int g, input logic [7:0] mo, input int nb,
                       output logic [7:0] mi);
      logic pha;
      pha = g[0];
      mi = '0;
      for (int i = 0; i < nb; i++) begin
         if (!pha) begin
            mosi[g] = mo[7-i];
            wait_clk(H);
            mi[7-i] = miso[g];
            sclk[g] = ~sclk[g];
            wait_clk(H);
            sclk[g] = ~sclk[g];
         end else begin
            sclk[g] = ~sclk[g];
            mosi[g] = mo[7-i];
            wait_clk(H);
            mi[7-i] = miso[g];
            sclk[g] = ~sclk[g];
            wait_clk(H);
         end
      end
      if (!pha) wait_clk(2);
   endtask

   task automatic test_reset();
      for (int g = 0; g < 4; g++) begin
         checks++;
         if ({miso[g], tx_ready[g], rx_valid[g], busy[g], tx_underrun[g]}
             !== 5'b01000 || rx_data[g] !== 8'h00) begin
            failures++;
            $display("FAIL reset dut%0d: miso/rdy/vld/busy/un=%b%b%b%b%b rx=%h required 01000 00",
                     g, miso[g], tx_ready[g], rx_valid[g], busy[g],
                     tx_underrun[g], rx_data[g]);
         end
      end
   endtask

   task automatic test_mode00();
      logic [7:0] mi;
      int r0, u0;
      r0 = rxc[0]; u0 = unc[0];
      load(0, 8'h3C);
      checks++;
      if (tx_ready[0] !== 1'b0) begin
         failures++;
         $display("FAIL m00_loaded: tx_ready=%b required 0", tx_ready[0]);
      end
      ss_low(0);
      checks++;
      if (busy[0] !== 1'b1 || tx_ready[0] !== 1'b1) begin
         failures++;
         $display("FAIL m00_start: busy=%b tx_ready=%b required 1 1", busy[0], tx_ready[0]);
      end
      xfer(0, 8'hA5, 8, mi);
      checks++;
      if (mi !== 8'h3C) begin
         failures++;
         $display("FAIL m00_miso: got %h required 3c", mi);
      end
      checks++;
      if (rx_data[0] !== 8'hA5 || rxc[0] - r0 !== 1) begin
         failures++;
         $display("FAIL m00_rx: rx=%h pulses=%0d required a5 1", rx_data[0], rxc[0] - r0);
      end
      ss_high(0);
      checks++;
      if (busy[0] !== 1'b0 || miso[0] !== 1'b0 || unc[0] - u0 !== 0) begin
         failures++;
         $display("FAIL m00_end: busy=%b miso=%b under=%0d required 0 0 0",
                  busy[0], miso[0], unc[0] - u0);
      end
   endtask

   task automatic test_modes();
      logic [7:0] mi;
      int r0, u0;
      for (int g = 1; g < 4; g++) begin
         r0 = rxc[g]; u0 = unc[g];
         load(g, 8'h7E);
         ss_low(g);
         xfer(g, 8'h81, 8, mi);
         ss_high(g);
         checks++;
         if (mi !== 8'h7E || rx_data[g] !== 8'h81 || rxc[g] - r0 !== 1
             || unc[g] - u0 !== 0) begin
            failures++;
            $display("FAIL mode%0d: miso=%h rx=%h pulses=%0d under=%0d required 7e 81 1 0",
                     g, mi, rx_data[g], rxc[g] - r0, unc[g] - u0);
         end
      end
   endtask

   task automatic test_shadow_hold();
      logic [7:0] mi;
      load(1, 8'h12);
      load(1, 8'h34);
      ss_low(1);
      xfer(1, 8'h00, 8, mi);
      ss_high(1);
      checks++;
      if (mi !== 8'h12) begin
         failures++;
         $display("FAIL shadow_hold: miso=%h required 12", mi);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] m1, m2, m3;
      int r0, u0;
      r0 = rxc[0]; u0 = unc[0];
      load(0, 8'hE1);
      ss_low(0);
      wait_ready(0);
      load(0, 8'hD2);
      xfer(0, 8'h11, 8, m1);
      xfer(0, 8'h22, 8, m2);
      wait_ready(0);
      load(0, 8'hC3);
      xfer(0, 8'h33, 8, m3);
      ss_high(0);
      checks++;
      if ({m1, m2, m3} !== 24'hE1D2C3) begin
         failures++;
         $display("FAIL b2b_miso: got %h %h %h required e1 d2 c3", m1, m2, m3);
      end
      checks++;
      if (rxc[0] - r0 !== 3 || rxh[0][r0 % 64] !== 8'h11
          || rxh[0][(r0 + 1) % 64] !== 8'h22 || rxh[0][(r0 + 2) % 64] !== 8'h33) begin
         failures++;
         $display("FAIL b2b_rx: pulses=%0d words=%h %h %h required 3 11 22 33",
                  rxc[0] - r0, rxh[0][r0 % 64], rxh[0][(r0 + 1) % 64],
                  rxh[0][(r0 + 2) % 64]);
      end
      checks++;
      if (unc[0] - u0 !== 0) begin
         failures++;
         $display("FAIL b2b_under: pulses=%0d required 0", unc[0] - u0);
      end
   endtask

   task automatic test_underrun();
      logic [7:0] m1, m2;
      int r0, u0;
      r0 = rxc[0]; u0 = unc[0];
      load(0, 8'h5A);
      ss_low(0);
      xfer(0, 8'h0F, 8, m1);
      xfer(0, 8'hF0, 8, m2);
      ss_high(0);
      checks++;
      if (m1 !== 8'h5A || m2 !== 8'h00) begin
         failures++;
         $display("FAIL under_miso: got %h %h required 5a 00", m1, m2);
      end
      checks++;
      if (unc[0] - u0 !== 1) begin
         failures++;
         $display("FAIL under_pulse: pulses=%0d required 1", unc[0] - u0);
      end
      checks++;
      if (rxc[0] - r0 !== 2 || rx_data[0] !== 8'hF0) begin
         failures++;
         $display("FAIL under_rx: pulses=%0d rx=%h required 2 f0", rxc[0] - r0, rx_data[0]);
      end
   endtask

   task automatic test_abort();
      logic [7:0] mi;
      int r0;
      r0 = rxc[0];
      load(0, 8'h96);
      ss_low(0);
      xfer(0, 8'hC3, 5, mi);
      ss_high(0);
      checks++;
      if (rxc[0] - r0 !== 0 || busy[0] !== 1'b0) begin
         failures++;
         $display("FAIL abort: pulses=%0d busy=%b required 0 0", rxc[0] - r0, busy[0]);
      end
      load(0, 8'h69);
      ss_low(0);
      xfer(0, 8'h3A, 8, mi);
      ss_high(0);
      checks++;
      if (mi !== 8'h69 || rx_data[0] !== 8'h3A || rxc[0] - r0 !== 1) begin
         failures++;
         $display("FAIL abort_next: miso=%h rx=%h pulses=%0d required 69 3a 1",
                  mi, rx_data[0], rxc[0] - r0);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] mi;
      int r0;
      r0 = rxc[0];
      load(0, 8'h55);
      ss_low(0);
      load(0, 8'hAA);
      xfer(0, 8'hFF, 4, mi);
      reset = 1'b0;
      wait_clk(3);
      checks++;
      if ({miso[0], tx_ready[0], rx_valid[0], busy[0], tx_underrun[0]}
          !== 5'b01000 || rx_data[0] !== 8'h00) begin
         failures++;
         $display("FAIL rst_mid: miso/rdy/vld/busy/un=%b%b%b%b%b rx=%h required 01000 00",
                  miso[0], tx_ready[0], rx_valid[0], busy[0], tx_underrun[0], rx_data[0]);
      end
      reset = 1'b1;
      wait_clk(20);
      checks++;
      if (busy[0] !== 1'b0 || rxc[0] - r0 !== 0) begin
         failures++;
         $display("FAIL rst_rearm: busy=%b pulses=%0d required 0 0", busy[0], rxc[0] - r0);
      end
      ss_high(0);
      load(0, 8'hC6);
      ss_low(0);
      xfer(0, 8'h9B, 8, mi);
      ss_high(0);
      checks++;
      if (mi !== 8'hC6 || rx_data[0] !== 8'h9B || rxc[0] - r0 !== 1) begin
         failures++;
         $display("FAIL rst_next: miso=%h rx=%h pulses=%0d required c6 9b 1",
                  mi, rx_data[0], rxc[0] - r0);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) tx_data[i] = 8'h00;
      wait_clk(5);
      test_reset();
      reset = 1'b1;
      wait_clk(10);
      test_mode00();
      test_modes();
      test_shadow_hold();
      test_back_to_back();
      test_underrun();
      test_abort();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
